latch_pipe_stage: RTL

Parametrised, back-pressure-capable pipeline stage register for the CPU datapath. It carries CHANNELS independent register-write requests (enable, address, data) between two pipeline stages. It adds a valid/ready handshake, a one-entry skid buffer for full throughput under stall, and a synchronous flush. It replaces the fixed-width EX/MEM-style latches wherever a stage must stall or squash.

---
 rtl/latch_pipe_stage_pkg.sv | 23 ++
 rtl/latch_payload_register.sv | 42 ++++
 rtl/latch_pipe_stage.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/latch_pipe_stage_pkg.sv
// Shared definitions for the stallable pipeline stage register: FSM state encodings,
// write-channel indices and write-enable constants.
package latch_pipe_stage_pkg;

    typedef enum logic [1:0] {
        STATE_EMPTY = 2'd0,
        STATE_ONE   = 2'd1,
        STATE_TWO   = 2'd2
    } state_t;

    localparam int CHANNEL_GPR = 0;
    localparam int CHANNEL_HI  = 1;
    localparam int CHANNEL_LO  = 2;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    // Packed width of one stored beat: per channel one enable, one address, one data word.
    function automatic int payload_width(input int channels, input int addr_width, input int data_width);
        return channels * (1 + addr_width + data_width);
    endfunction

endpackage

// File: rtl/latch_payload_register.sv
// One storage entry of the stage: a load-enabled register holding {enables, addresses, data}
// whose enable field can be squashed synchronously while address/data keep their value.
module latch_payload_register
    import latch_pipe_stage_pkg::*;
#(
    parameter int CHANNELS   = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    localparam int WIDTH     = payload_width(CHANNELS, ADDR_WIDTH, DATA_WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             clear_enables,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    localparam int FIELD_WIDTH = CHANNELS * (ADDR_WIDTH + DATA_WIDTH);

    logic [WIDTH-1:0] payload_r;

    // Payload storage; clearing only touches the enable field at the top of the word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            payload_r <= {WIDTH{1'b0}};
        end else if (clear_enables) begin
            if (load) begin
                payload_r <= {{CHANNELS{WRITE_DISABLE}}, d[FIELD_WIDTH-1:0]};
            end else begin
                payload_r <= {{CHANNELS{WRITE_DISABLE}}, payload_r[FIELD_WIDTH-1:0]};
            end
        end else if (load) begin
            payload_r <= d;
        end else begin
            payload_r <= payload_r;
        end
    end

    assign q = payload_r;

endmodule

// File: rtl/latch_pipe_stage.sv
// Valid/ready pipeline stage for register-write requests with a one-entry skid buffer
// and synchronous flush; main entry drives the outputs, skid absorbs one beat under stall.
module latch_pipe_stage
    import latch_pipe_stage_pkg::*;
#(
    parameter int CHANNELS   = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CHANNELS-1:0]            in_write_enable,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] in_write_address,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_write_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CHANNELS-1:0]            out_write_enable,
    output logic [CHANNELS*ADDR_WIDTH-1:0] out_write_address,
    output logic [CHANNELS*DATA_WIDTH-1:0] out_write_data,
    output logic [1:0]                     occupancy
);

    localparam int WIDTH       = payload_width(CHANNELS, ADDR_WIDTH, DATA_WIDTH);
    localparam int FIELD_WIDTH = CHANNELS * (ADDR_WIDTH + DATA_WIDTH);

    state_t           state_r;
    logic             in_ready_s;
    logic             out_valid_s;
    logic             accept_s;
    logic             take_s;
    logic             main_load_s;
    logic             skid_load_s;
    logic             main_from_skid_s;
    logic [WIDTH-1:0] in_payload_s;
    logic [WIDTH-1:0] main_d_s;
    logic [WIDTH-1:0] main_q_s;
    logic [WIDTH-1:0] skid_q_s;

    // Handshake is decoded purely from the state register, so in_ready never sees out_ready.
    assign in_ready_s  = (state_r != STATE_TWO);
    assign out_valid_s = (state_r != STATE_EMPTY);
    assign accept_s    = in_valid & in_ready_s;
    assign take_s      = out_valid_s & out_ready;

    assign in_payload_s = {in_write_enable, in_write_address, in_write_data};

    // Storage load decode; a flush suppresses every load so the input beat is discarded.
    always_comb begin
        main_load_s      = 1'b0;
        skid_load_s      = 1'b0;
        main_from_skid_s = 1'b0;
        if (flush) begin
            main_load_s = 1'b0;
            skid_load_s = 1'b0;
        end else begin
            case (state_r)
                STATE_EMPTY: begin
                    main_load_s = accept_s;
                end
                STATE_ONE: begin
                    main_load_s = accept_s & take_s;
                    skid_load_s = accept_s & ~take_s;
                end
                STATE_TWO: begin
                    main_load_s      = take_s;
                    main_from_skid_s = take_s;
                end
                default: begin
                    main_load_s = 1'b0;
                end
            endcase
        end
    end

    // Main entry is refilled from the skid when the stage drains out of TWO, keeping FIFO order.
    always_comb begin
        if (main_from_skid_s) begin
            main_d_s = skid_q_s;
        end else begin
            main_d_s = in_payload_s;
        end
    end

    // Occupancy FSM; flush returns to EMPTY regardless of the handshake in that cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= STATE_EMPTY;
        end else if (flush) begin
            state_r <= STATE_EMPTY;
        end else begin
            case (state_r)
                STATE_EMPTY: begin
                    if (accept_s) state_r <= STATE_ONE;
                    else          state_r <= STATE_EMPTY;
                end
                STATE_ONE: begin
                    if (accept_s && !take_s)      state_r <= STATE_TWO;
                    else if (take_s && !accept_s) state_r <= STATE_EMPTY;
                    else                          state_r <= STATE_ONE;
                end
                STATE_TWO: begin
                    if (take_s) state_r <= STATE_ONE;
                    else        state_r <= STATE_TWO;
                end
                default: begin
                    state_r <= STATE_EMPTY;
                end
            endcase
        end
    end

    latch_payload_register #(
        .CHANNELS   (CHANNELS),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_main (
        .clock         (clock),
        .reset         (reset),
        .load          (main_load_s),
        .clear_enables (flush),
        .d             (main_d_s),
        .q             (main_q_s)
    );

    latch_payload_register #(
        .CHANNELS   (CHANNELS),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_skid (
        .clock         (clock),
        .reset         (reset),
        .load          (skid_load_s),
        .clear_enables (flush),
        .d             (in_payload_s),
        .q             (skid_q_s)
    );

    // Enables are gated by valid so an empty stage can never issue a register write.
    assign in_ready          = in_ready_s;
    assign out_valid         = out_valid_s;
    assign out_write_enable  = main_q_s[WIDTH-1 -: CHANNELS] & {CHANNELS{out_valid_s}};
    assign out_write_address = main_q_s[FIELD_WIDTH-1 -: CHANNELS*ADDR_WIDTH];
    assign out_write_data    = main_q_s[CHANNELS*DATA_WIDTH-1:0];
    assign occupancy         = state_r;

endmodule
